// File: rtl/uart_word_rx.sv
// uart_word_rx: UART receive path that deserialises 8N1 bytes from a 2-flop synchronised
// serial line and packs four good bytes (byte0 in [7:0]) into a 32-bit word. The word is
// offered on a valid/ack handshake. Framing errors, dropped words and inter-byte timeouts
// are flagged.
// Define UART_PARITY_EN to receive 8E1 frames; a parity failure is reported like a bad
// stop bit.
module uart_word_rx #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned TIMEOUT_CLKS = 43400
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  input  logic        data_ack,
  input  logic        err_clr,
  output logic [31:0] data,
  output logic        data_valid,
  output logic        frame_err,
  output logic        overrun,
  output logic        timeout,
  output logic        busy
);

  localparam int unsigned TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned IW = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
  localparam logic [TW-1:0] BitLast  = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] BitHalf  = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IW-1:0] IdleLast = IW'(TIMEOUT_CLKS - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop
`ifdef UART_PARITY_EN
    , StParity
`endif
  } state_e;

  logic          rx_meta, rx_sync, rx_prev;
  state_e        state;
  logic [TW-1:0] timer;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          byte_done;
  logic [7:0]    byte_buf;
  logic          stop_ok;
  logic          start_det;
  logic [1:0]    byte_cnt;
  logic [23:0]   asm_lo;
  logic          word_done;
  logic [31:0]   word_buf;
  logic [IW-1:0] idle_cnt;

`ifdef UART_PARITY_EN
  logic parity_bad;
  assign stop_ok = rx_sync && !parity_bad;
`else
  assign stop_ok = rx_sync;
`endif

  assign start_det = (state == StIdle) && rx_prev && !rx_sync;

  // Two-flop synchroniser plus one delay stage for falling-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // Bit-level receive FSM; emits a one-cycle byte_done or frame_err at the stop sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= StIdle;
      timer     <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      busy      <= 1'b0;
      frame_err <= 1'b0;
      byte_done <= 1'b0;
      byte_buf  <= '0;
`ifdef UART_PARITY_EN
      parity_bad <= 1'b0;
`endif
    end else begin
      frame_err <= 1'b0;
      byte_done <= 1'b0;
      case (state)
        StIdle: begin
          if (start_det) begin
            state <= StStart;
            timer <= '0;
            busy  <= 1'b1;
          end
        end
        StStart: begin
          if (timer == BitHalf) begin
            timer <= '0;
            if (rx_sync) begin
              // Line went back high before mid-bit: treat as a glitch.
              state <= StIdle;
              busy  <= 1'b0;
            end else begin
              state   <= StData;
              bit_idx <= '0;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        StData: begin
          if (timer == BitLast) begin
            timer   <= '0;
            shift   <= {rx_sync, shift[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
`ifdef UART_PARITY_EN
              state <= StParity;
`else
              state <= StStop;
`endif
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
`ifdef UART_PARITY_EN
        StParity: begin
          if (timer == BitLast) begin
            timer      <= '0;
            parity_bad <= ^{shift, rx_sync};
            state      <= StStop;
          end else begin
            timer <= timer + 1'b1;
          end
        end
`endif
        StStop: begin
          if (timer == BitLast) begin
            timer <= '0;
            state <= StIdle;
            busy  <= 1'b0;
            if (stop_ok) begin
              byte_done <= 1'b1;
              byte_buf  <= shift;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: begin
          state <= StIdle;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Word assembly and inter-byte timeout; a frame error or timeout discards the partial word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_cnt  <= '0;
      asm_lo    <= '0;
      word_done <= 1'b0;
      word_buf  <= '0;
      idle_cnt  <= '0;
      timeout   <= 1'b0;
    end else begin
      word_done <= 1'b0;
      timeout   <= 1'b0;
      if (frame_err) begin
        byte_cnt <= '0;
      end else if (byte_done) begin
        byte_cnt <= byte_cnt + 2'd1;
        case (byte_cnt)
          2'd0:    asm_lo[7:0]   <= byte_buf;
          2'd1:    asm_lo[15:8]  <= byte_buf;
          2'd2:    asm_lo[23:16] <= byte_buf;
          default: begin
            word_done <= 1'b1;
            word_buf  <= {byte_buf, asm_lo};
          end
        endcase
      end
      if (start_det || (state != StIdle) || (byte_cnt == 2'd0)) begin
        idle_cnt <= '0;
      end else if (idle_cnt == IdleLast) begin
        idle_cnt <= '0;
        byte_cnt <= '0;
        timeout  <= 1'b1;
      end else begin
        idle_cnt <= idle_cnt + 1'b1;
      end
    end
  end

  // Consumer handshake; a word completing onto an unacked word is dropped and flagged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data       <= '0;
      data_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (err_clr) overrun <= 1'b0;
      if (word_done) begin
        if (!data_valid || data_ack) begin
          data       <= word_buf;
          data_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;  // later assignment: a new overrun beats err_clr
        end
      end else if (data_ack && data_valid) begin
        data_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_word_rx.sv
// Directed self-checking bench for uart_word_rx (CLKS_PER_BIT = 8, TIMEOUT_CLKS = 200).
// Inputs are driven on falling edges; outputs are read on falling edges.
module tb_uart_word_rx;

  localparam int unsigned CPB = 8;
  localparam int unsigned TO  = 200;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx;
  logic        data_ack;
  logic        err_clr;
  logic [31:0] data;
  logic        data_valid;
  logic        frame_err;
  logic        overrun;
  logic        timeout;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int fe_cnt = 0;
  int to_cnt = 0;
  int fe0;
  int to0;
  logic saw_busy;

  uart_word_rx #(
    .CLKS_PER_BIT(CPB),
    .TIMEOUT_CLKS(TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .data_ack   (data_ack),
    .err_clr    (err_clr),
    .data       (data),
    .data_valid (data_valid),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .timeout    (timeout),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Pulse counters, sampled just after the rising edge.
  always @(posedge clk) begin
    #1;
    if (frame_err === 1'b1) fe_cnt++;
    if (timeout === 1'b1) to_cnt++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Drives start, data (and parity) bits, then leaves the stop level on the line.
  task automatic send_bits(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (CPB) tick();
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) tick();
    end
`ifdef UART_PARITY_EN
    rx = ^b;
    repeat (CPB) tick();
`endif
    rx = stop;
  endtask

  task automatic finish_byte();
    repeat (CPB) tick();
    rx = 1'b1;
    repeat (4) tick();
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_bits(b, 1'b1);
    finish_byte();
  endtask

  // Sends a word; the last byte is followed edge-by-edge so data_valid latency and the
  // completion-cycle ack can be placed exactly.
  task automatic send_word(input logic [31:0] w, input logic ack_cmpl, input logic chk_lat);
    send_byte(w[7:0]);
    send_byte(w[15:8]);
    send_byte(w[23:16]);
    send_bits(w[31:24], 1'b1);
    for (int n = 0; n < 20 && busy; n++) tick();
    chk("busy_falls_after_stop", 32'(busy), 32'h0);
    if (chk_lat) chk("dv_low_at_stop_sample", 32'(data_valid), 32'h0);
    tick();
    if (chk_lat) chk("dv_low_one_clock_after", 32'(data_valid), 32'h0);
    if (ack_cmpl) data_ack = 1'b1;
    tick();
    data_ack = 1'b0;
    if (chk_lat) chk("dv_high_two_clocks_after", 32'(data_valid), 32'h1);
    rx = 1'b1;
    repeat (4) tick();
  endtask

  task automatic ack_word();
    data_ack = 1'b1;
    tick();
    data_ack = 1'b0;
    chk("dv_cleared_by_ack", 32'(data_valid), 32'h0);
  endtask

`ifdef UART_PARITY_EN
  task automatic send_bits_par(input logic [7:0] b, input logic par);
    rx = 1'b0;
    repeat (CPB) tick();
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) tick();
    end
    rx = par;
    repeat (CPB) tick();
    rx = 1'b1;
  endtask
`endif

  initial begin
    rst      = 1'b1;
    rx       = 1'b1;
    data_ack = 1'b0;
    err_clr  = 1'b0;
    repeat (3) tick();
    chk("rst_data", data, 32'h0);
    chk("rst_dv", 32'(data_valid), 32'h0);
    chk("rst_frame_err", 32'(frame_err), 32'h0);
    chk("rst_overrun", 32'(overrun), 32'h0);
    chk("rst_timeout", 32'(timeout), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    rst = 1'b0;
    repeat (4) tick();

    // Basic word and ack.
    send_word(32'h1234_5678, 1'b0, 1'b1);
    chk("t1_data", data, 32'h1234_5678);
    ack_word();
    chk("t1_data_held", data, 32'h1234_5678);
    chk("t1_no_frame_err", 32'(fe_cnt), 32'h0);
    chk("t1_no_overrun", 32'(overrun), 32'h0);

    // Start-bit glitch.
    rx = 1'b0;
    tick();
    tick();
    rx = 1'b1;
    saw_busy = 1'b0;
    for (int n = 0; n < 12; n++) begin
      tick();
      if (busy) saw_busy = 1'b1;
    end
    chk("glitch_busy_seen", 32'(saw_busy), 32'h1);
    chk("glitch_busy_back_low", 32'(busy), 32'h0);
    chk("glitch_no_frame_err", 32'(fe_cnt), 32'h0);
    send_word(32'hA1B2_C3D4, 1'b0, 1'b1);
    chk("glitch_word", data, 32'hA1B2_C3D4);
    ack_word();

    // Framing error after two good bytes discards the partial word.
    fe0 = fe_cnt;
    send_byte(8'h11);
    send_byte(8'h22);
    send_bits(8'hAA, 1'b0);
    repeat (CPB) tick();
    rx = 1'b1;
    repeat (8) tick();
    chk("fe_one_pulse", 32'(fe_cnt - fe0), 32'h1);
    send_word(32'h0403_0201, 1'b0, 1'b1);
    chk("fe_next_word", data, 32'h0403_0201);
    ack_word();

    // Overrun, err_clr, then ack in the completion cycle.
    send_word(32'hDEAD_BEEF, 1'b0, 1'b1);
    chk("ov_first_word", data, 32'hDEAD_BEEF);
    send_word(32'hCAFE_F00D, 1'b0, 1'b0);
    chk("ov_data_kept", data, 32'hDEAD_BEEF);
    chk("ov_flag_set", 32'(overrun), 32'h1);
    chk("ov_dv_still_high", 32'(data_valid), 32'h1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("ov_cleared", 32'(overrun), 32'h0);
    send_word(32'hCAFE_F00D, 1'b1, 1'b0);
    chk("ack_cmpl_data", data, 32'hCAFE_F00D);
    chk("ack_cmpl_dv", 32'(data_valid), 32'h1);
    chk("ack_cmpl_no_overrun", 32'(overrun), 32'h0);

    // Inter-byte timeout.
    to0 = to_cnt;
    send_byte(8'h55);
    send_byte(8'h66);
    repeat (250) tick();
    chk("to_one_pulse", 32'(to_cnt - to0), 32'h1);
    chk("to_dv_unaffected", 32'(data_valid), 32'h1);
    chk("to_data_unaffected", data, 32'hCAFE_F00D);
    ack_word();
    send_word(32'h4433_2211, 1'b0, 1'b1);
    chk("to_next_word", data, 32'h4433_2211);

    // Asynchronous reset in the middle of the second byte.
    send_byte(8'h9A);
    rx = 1'b0;
    repeat (CPB) tick();
    rx = 1'b1;
    repeat (3 * CPB) tick();
    chk("pre_rst_busy", 32'(busy), 32'h1);
    #2;
    rst = 1'b1;
    rx  = 1'b1;
    #1;
    chk("arst_data", data, 32'h0);
    chk("arst_dv", 32'(data_valid), 32'h0);
    chk("arst_busy", 32'(busy), 32'h0);
    chk("arst_overrun", 32'(overrun), 32'h0);
    chk("arst_frame_err", 32'(frame_err), 32'h0);
    chk("arst_timeout", 32'(timeout), 32'h0);
    repeat (2) tick();
    rst = 1'b0;
    repeat (4) tick();
    send_word(32'h0BAD_F00D, 1'b0, 1'b1);
    chk("post_rst_word", data, 32'h0BAD_F00D);
    ack_word();

`ifdef UART_PARITY_EN
    // Bad parity on 0x03 is reported at the stop sample and discards the byte.
    fe0 = fe_cnt;
    send_bits_par(8'h03, 1'b1);
    finish_byte();
    chk("par_bad_frame_err", 32'(fe_cnt - fe0), 32'h1);
    send_word(32'h7F80_0003, 1'b0, 1'b1);
    chk("par_good_word", data, 32'h7F80_0003);
    ack_word();
    chk("total_frame_err", 32'(fe_cnt), 32'h2);
`else
    chk("total_frame_err", 32'(fe_cnt), 32'h1);
`endif
    chk("total_timeout", 32'(to_cnt), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_word_rx.md
Name: uart_word_rx

Overview:
- UART receive path from the PC: deserialises 8N1 bytes on the serial input and assembles four consecutive bytes into one 32-bit word.
- Complement of the word-send path: the 32-bit word sent to the PC is the unit received back.
- Presents each word with a valid/ack handshake to host-command logic.
- Flags framing errors, overrun and inter-byte timeout.

Parameters:
- CLKS_PER_BIT, 434, clocks per UART bit (50 MHz / 115200). Must be >= 4.
- TIMEOUT_CLKS, 43400, idle clocks after a completed byte before a partial word is discarded.

Ports:
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-high
- rx  input  1  serial line from PC, idle high, asynchronous to clk
- data_ack  input  1  consumer accepts current word
- err_clr  input  1  clears the sticky overrun flag
- data  output  32  assembled word; byte0 in [7:0], byte3 in [31:24]
- data_valid  output  1  word available; held until acked
- frame_err  output  1  one-cycle pulse on a bad stop bit
- overrun  output  1  sticky: a completed word was dropped
- timeout  output  1  one-cycle pulse when a partial word is discarded
- busy  output  1  high from start-bit detect to end of stop bit

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values:
  - data = 0, data_valid = 0, frame_err = 0, overrun = 0, timeout = 0, busy = 0.
  - Byte count = 0; FSM in IDLE.
  - rx synchroniser flops = 1.
  - Reset mid-frame aborts everything; a partial word is lost.
- rx passes through a 2-flop synchroniser. All sampling uses the synchronised signal.
- FSM states: IDLE, START, DATA, STOP (plus PARITY when the optional feature is enabled).
  - IDLE: on a synced 1->0 edge, go to START, clear the bit timer, set busy = 1.
  - START: at timer = CLKS_PER_BIT/2 - 1, sample the line.
    - If 1 (glitch): return to IDLE, busy = 0, no error.
    - Else: go to DATA with timer cleared.
  - DATA: sample every CLKS_PER_BIT clocks, 8 bits, LSB first, into a shift register.
  - STOP: sample after CLKS_PER_BIT clocks.
    - If 1: the byte is good.
    - If 0: pulse frame_err, discard the byte AND the partial word (byte count = 0).
    - Return to IDLE with busy = 0 in the cycle after the sample.
    - A new start edge is accepted from the next cycle.
- Word assembly:
  - A good byte is written to lane [byte_cnt*8 +: 8] of the assembly register; byte_cnt increments.
  - On the 4th good byte, byte_cnt wraps to 0 and the word completes.
- Handshake:
  - Word completes with data_valid = 0: next cycle data = word, data_valid = 1.
  - Word completes with data_valid = 1 and data_ack = 0 in the same cycle: the word is dropped, data is unchanged, overrun is set.
  - Word completes with data_valid = 1 and data_ack = 1 in the same cycle: the new word is loaded, data_valid stays 1, no overrun.
  - data_ack with data_valid = 1 and no completion: data_valid = 0 next cycle; data is held.
  - data_ack with data_valid = 0 is ignored.
- overrun clears only on err_clr (or rst). If err_clr coincides with a new overrun event, set wins.
- Timeout:
  - An idle counter runs while FSM = IDLE and byte_cnt != 0. It resets on every start detect.
  - On reaching TIMEOUT_CLKS - 1: byte_cnt = 0, timeout pulses one cycle.
  - data and data_valid are unaffected.
- Word latency: data_valid rises 2 clocks after the stop-bit sample of byte 3 (1 for assembly + 1 for the register). The bench checks this exactly.

Optional Feature:
- Macro: UART_PARITY_EN
- Defined:
  - Frame is 8E1. A PARITY state samples one bit after the 8th data bit.
  - If the XOR of the data bits and the parity bit is 1: the byte and the partial word are discarded, and frame_err pulses at the stop sample instead of accepting the byte.
  - Stop-bit checking is unchanged.
- Undefined: 8N1. No PARITY state and no parity logic.

Test Plan (CLKS_PER_BIT = 8, TIMEOUT_CLKS = 200):
- Send bytes 0x78, 0x56, 0x34, 0x12 back-to-back -> data = 0x12345678, data_valid = 1 two clocks after the last stop sample. Pulse data_ack -> data_valid = 0 next cycle; no errors.
- 2-clock low glitch on idle rx -> busy pulses and returns to 0; no byte counted. A following 4-byte word is assembled correctly.
- Send 0xAA with stop bit = 0 after 2 good bytes -> frame_err pulses once. The next 4 bytes 0x01, 0x02, 0x03, 0x04 yield data = 0x04030201.
- Send two full words without ack: 0xDEADBEEF then 0xCAFEF00D -> data stays 0xDEADBEEF, overrun = 1. err_clr -> overrun = 0. Repeat with data_ack asserted in the completion cycle -> data = 0xCAFEF00D, overrun stays 0.
- Send 2 bytes, then hold rx high for 200 clocks -> timeout pulses once. The next 4 bytes 0x11, 0x22, 0x33, 0x44 yield 0x44332211.
- Assert rst during the DATA state of byte 2 -> all outputs are 0 immediately (asynchronous). A full word sent after release is received correctly.
- With UART_PARITY_EN defined: byte 0x03 with parity 1 -> frame_err pulses. Parity 0 -> byte accepted.
